screen_memory: RTL

- Owns the 64x32 monochrome CHIP-8 framebuffer: 256 bytes, byte address {y[4:0], x[5:3]}, bit 7 = leftmost pixel.
- Serves as the responder for the display bridge's scr_read/scr_read_idx/scr_read_byte/scr_read_ack read handshake.
- Serves the CPU side with two commands: sprite-row XOR draw with collision detection, and full-screen clear.
- Sits between the CPU core and the screen bridge on a single-port RAM; bridge reads have per-cycle priority.

---
 rtl/screen_memory_if.sv | 25 ++
 rtl/screen_memory.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/screen_memory_if.sv
// Bridge-side read handshake between the display scanner and the framebuffer.
`timescale 1ns/1ps
interface screen_memory_if;
  logic       scr_busy;
  logic       scr_read;
  logic [7:0] scr_read_idx;
  logic [7:0] scr_read_byte;
  logic       scr_read_ack;

  modport master (
    output scr_busy,
    output scr_read,
    output scr_read_idx,
    input  scr_read_byte,
    input  scr_read_ack
  );

  modport slave (
    input  scr_busy,
    input  scr_read,
    input  scr_read_idx,
    output scr_read_byte,
    output scr_read_ack
  );
endinterface

// File: rtl/screen_memory.sv
// CHIP-8 64x32 framebuffer on a single-port RAM: bridge reads take priority,
// CPU side performs sprite-row XOR draws with collision detect and full clears.
`timescale 1ns/1ps
module screen_memory #(
  parameter bit WAIT_FOR_SCAN = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  screen_memory_if.slave        bus,
  input  logic                  draw_req,
  input  logic [5:0]            draw_x,
  input  logic [4:0]            draw_y,
  input  logic [7:0]            draw_byte,
  input  logic                  clear_req,
  output logic                  ready,
  output logic                  done,
  output logic                  collision
);

  typedef enum logic [3:0] {
    S_IDLE, S_RD0, S_LT0, S_WR0, S_RD1, S_LT1, S_WR1, S_CLR, S_FIN
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [5:0] x_q, x_d;
  logic [4:0] y_q, y_d;
  logic [7:0] byte_q, byte_d;
  logic [7:0] old_q, old_d;
  logic       coll_q, coll_d;
  logic       ack_q, ack_d;
  logic       done_q, done_d;
  logic       collision_q, collision_d;

  logic [7:0] mem [256];
  logic [7:0] ram_rd_q;
  logic [7:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_wdata;

  logic       bridge_req;
  logic       port_free;
  logic [2:0] shift;
  logic [2:0] col1;
  logic [3:0] lshift;
  logic [7:0] part0;
  logic [7:0] part1;
  logic [7:0] a0;
  logic [7:0] a1;
  logic [7:0] cpu_addr;
  logic       cpu_we;
  logic [7:0] cpu_wdata;

  // A request is only new when the previous cycle did not already ack it.
  assign bridge_req = bus.scr_read & ~ack_q;
  assign port_free  = ~bridge_req;

  assign shift  = x_q[2:0];
  assign col1   = x_q[5:3] + 3'd1;
  assign lshift = 4'd8 - {1'b0, shift};
  assign part0  = byte_q >> shift;
  assign part1  = byte_q << lshift;
  assign a0     = {y_q, x_q[5:3]};
  assign a1     = {y_q, col1};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    byte_d      = byte_q;
    old_d       = old_q;
    coll_d      = coll_q;
    ack_d       = bridge_req;
    done_d      = 1'b0;
    collision_d = collision_q;
    cpu_addr    = '0;
    cpu_we      = 1'b0;
    cpu_wdata   = '0;

    case (state_q)
      S_IDLE: begin
        if (port_free && (!WAIT_FOR_SCAN || !bus.scr_busy)) begin
          if (clear_req) begin
            state_d = S_CLR;
            cnt_d   = '0;
            coll_d  = 1'b0;
          end else if (draw_req) begin
            state_d = S_RD0;
            x_d     = draw_x;
            y_d     = draw_y;
            byte_d  = draw_byte;
            coll_d  = 1'b0;
          end
        end
      end
      S_RD0: begin
        cpu_addr = a0;
        if (port_free) state_d = S_LT0;
      end
      // Latch is unconditional: ram_rd_q still holds our read this cycle,
      // even if a bridge read is being issued alongside.
      S_LT0: begin
        old_d   = ram_rd_q;
        state_d = S_WR0;
      end
      S_WR0: begin
        cpu_addr  = a0;
        cpu_wdata = old_q ^ part0;
        cpu_we    = port_free;
        if (port_free) begin
          coll_d  = |(old_q & part0);
          state_d = (shift == 3'd0) ? S_FIN : S_RD1;
        end
      end
      S_RD1: begin
        cpu_addr = a1;
        if (port_free) state_d = S_LT1;
      end
      S_LT1: begin
        old_d   = ram_rd_q;
        state_d = S_WR1;
      end
      S_WR1: begin
        cpu_addr  = a1;
        cpu_wdata = old_q ^ part1;
        cpu_we    = port_free;
        if (port_free) begin
          coll_d  = coll_q | (|(old_q & part1));
          state_d = S_FIN;
        end
      end
      S_CLR: begin
        cpu_addr  = cnt_q;
        cpu_wdata = '0;
        cpu_we    = port_free;
        if (port_free) begin
          if (cnt_q == 8'hFF) state_d = S_FIN;
          else                cnt_d   = cnt_q + 8'd1;
        end
      end
      S_FIN: begin
        done_d      = 1'b1;
        collision_d = coll_q;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ram_addr  = bridge_req ? bus.scr_read_idx : cpu_addr;
    ram_we    = cpu_we;
    ram_wdata = cpu_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      byte_q      <= '0;
      old_q       <= '0;
      coll_q      <= 1'b0;
      ack_q       <= 1'b0;
      done_q      <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      byte_q      <= byte_d;
      old_q       <= old_d;
      coll_q      <= coll_d;
      ack_q       <= ack_d;
      done_q      <= done_d;
      collision_q <= collision_d;
    end
  end

  // Framebuffer contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rd_q <= mem[ram_addr];
  end

  assign ready             = (state_q == S_IDLE);
  assign done              = done_q;
  assign collision         = collision_q;
  assign bus.scr_read_ack  = ack_q;
  assign bus.scr_read_byte = ack_q ? ram_rd_q : '0;

endmodule
